// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 16;

  // Sequential PC increment in bytes (16-bit instructions).
  localparam int PC_STEP = 2;

  // Clears bit 0 of a redirect target; wide enough for any ADDR_W up to 64.
  localparam logic [63:0] ALIGN_MASK = ~64'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_FLUSH
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one-outstanding reads at the PC,
// hands instructions downstream over valid/ready and writes the next PC
// (sequential or redirected) back to the PC register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_cur,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               pc_write,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               misaligned
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  pc_next_q, pc_next_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               pc_write_q, pc_write_d;
  logic               imem_req_q, imem_req_d;
  logic               instr_valid_q, instr_valid_d;
  logic               misaligned_q, misaligned_d;

  logic [ADDR_W-1:0]  redir_pc;
  logic [ADDR_W-1:0]  seq_pc;
  logic               redir_take;

  assign redir_pc   = redirect_target & ALIGN_MASK[ADDR_W-1:0];
  assign seq_pc     = fetch_pc_q + STEP;
  // IDLE only samples pc_cur; a redirect there has nothing to steer yet.
  assign redir_take = redirect_valid && (state_q != ST_IDLE);

  // Next-state and next-output logic; a redirect overrides the sequential path.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pc_next_d     = pc_next_q;
    imem_addr_d   = imem_addr_q;
    instr_pc_d    = instr_pc_q;
    instr_d       = instr_q;
    imem_req_d    = imem_req_q;
    instr_valid_d = instr_valid_q;
    pc_write_d    = 1'b0;
    misaligned_d  = 1'b0;

    if (redir_take) begin
      fetch_pc_d    = redir_pc;
      pc_next_d     = redir_pc;
      pc_write_d    = 1'b1;
      misaligned_d  = redirect_target[0];
      instr_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        fetch_pc_d  = pc_cur;
        imem_addr_d = pc_cur;
        imem_req_d  = 1'b1;
        state_d     = ST_REQ;
      end
      ST_REQ: begin
        if (redir_take) begin
          // With an ack this cycle the data is dropped and the target is
          // requested right away; otherwise the in-flight read must drain.
          if (imem_ack) imem_addr_d = redir_pc;
          else          state_d     = ST_FLUSH;
        end else if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_pc_d    = imem_addr_q;
          instr_valid_d = 1'b1;
          fetch_pc_d    = seq_pc;
          pc_next_d     = seq_pc;
          pc_write_d    = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redir_take) begin
          imem_addr_d = redir_pc;
          imem_req_d  = 1'b1;
          state_d     = ST_REQ;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          imem_addr_d   = fetch_pc_q;
          imem_req_d    = 1'b1;
          state_d       = ST_REQ;
        end
      end
      ST_FLUSH: begin
        // Old read still outstanding; its data is discarded on ack and the
        // latest redirect target (held in fetch_pc) is requested instead.
        if (imem_ack) begin
          imem_addr_d = redir_take ? redir_pc : fetch_pc_q;
          state_d     = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= '0;
      pc_next_q     <= '0;
      imem_addr_q   <= '0;
      instr_pc_q    <= '0;
      instr_q       <= '0;
      pc_write_q    <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pc_next_q     <= pc_next_d;
      imem_addr_q   <= imem_addr_d;
      instr_pc_q    <= instr_pc_d;
      instr_q       <= instr_d;
      pc_write_q    <= pc_write_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign pc_next     = pc_next_q;
  assign pc_write    = pc_write_q;
  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign misaligned  = misaligned_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end; the reader and driver side of the PC register.
- Takes the current PC, issues one-outstanding reads to instruction memory, and presents fetched instructions downstream with a valid/ready handshake.
- Writes the next PC (PC+2 sequential, or a redirect target) back through the PC register's pc_in/pc_write port.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width.
- INSTR_W, 16, instruction width.
- PC_STEP, 2, sequential PC increment in bytes.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_cur  input  ADDR_W  PC register output (pc_out); sampled only in IDLE.
- pc_next  output  ADDR_W  value driven to the PC register pc_in.
- pc_write  output  1  PC register write enable; one-cycle pulse.
- imem_req  output  1  instruction-memory read request.
- imem_addr  output  ADDR_W  read address; stable while imem_req=1.
- imem_ack  input  1  read data valid; completes the request.
- imem_rdata  input  INSTR_W  read data, valid with imem_ack.
- instr_valid  output  1  fetched instruction available.
- instr  output  INSTR_W  fetched instruction.
- instr_pc  output  ADDR_W  address the instruction was fetched from.
- instr_ready  input  1  downstream accepts instr this cycle.
- redirect_valid  input  1  branch/jump taken; one-cycle pulse.
- redirect_target  input  ADDR_W  new fetch address.
- misaligned  output  1  one-cycle pulse: redirect_target bit 0 was 1.

Behaviour:
- All outputs are registered.
- Reset: state=IDLE. imem_req, pc_write, instr_valid and misaligned are 0. pc_next, imem_addr, instr and instr_pc are 0.
- Reset mid-operation: any outstanding request is abandoned. Instruction memory shares rst.
- States: IDLE, REQ, HOLD, FLUSH. An internal register fetch_pc tracks the PC register in lockstep.
- IDLE (exactly one cycle after reset release):
  - fetch_pc<=pc_cur and imem_addr<=pc_cur, then go to REQ.
  - redirect_valid is ignored in IDLE.
- REQ:
  - imem_req=1.
  - On imem_ack with no redirect:
    - instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1.
    - fetch_pc<=fetch_pc+PC_STEP and pc_next<=fetch_pc+PC_STEP, pc_write<=1.
    - imem_req<=0, go to HOLD.
  - Latency: ack in cycle N gives instr_valid and pc_write high in cycle N+1.
- HOLD:
  - instr_valid, instr and instr_pc are held stable while instr_ready=0.
  - On instr_ready: instr_valid<=0, imem_addr<=fetch_pc, go to REQ. The next request is visible in the following cycle.
- Redirect (REQ, HOLD or FLUSH); takes priority over the sequential increment:
  - t = redirect_target with bit 0 cleared. fetch_pc<=t, pc_next<=t, pc_write<=1.
  - misaligned<=redirect_target[0].
  - instr_valid<=0. A held instruction is dropped unless instr_ready was high in the same cycle; in that case the handshake counts as completed.
  - REQ without ack: imem_req and imem_addr stay unchanged, go to FLUSH.
  - REQ with imem_ack in the same cycle: discard the data, imem_addr<=t, stay in REQ (new request next cycle).
  - HOLD: imem_addr<=t, go to REQ.
  - FLUSH: latch the new t; the latest redirect wins.
- FLUSH:
  - imem_req held at 1 with the old address.
  - On imem_ack: discard the data, imem_addr<=fetch_pc, go to REQ.
- Arithmetic: PC addition is modulo 2^ADDR_W. 0xFFFE+2 wraps to 0x0000 with no flag.
- pc_write is never high in two consecutive cycles unless redirects arrive back to back.
- Exactly one outstanding request at any time. imem_req never drops before imem_ack.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum (IDLE, REQ, HOLD, FLUSH);
  - ADDR_W and INSTR_W defaults;
  - PC_STEP;
  - the alignment mask constant.
- Single module; no sub-module is warranted. The next-PC adder and mux stay inline.

Test Plan:
- Sequential fetch: pc_cur=0x0000 at reset release, memory acks with a 1-cycle delay returning 0x1111 then 0x2222, instr_ready held at 1 → imem_addr sequence 0x0000, 0x0002; instr/instr_pc = 0x1111/0x0000 then 0x2222/0x0002; pc_write pulses carry pc_next 0x0002, 0x0004.
- Backpressure: instr_ready=0 for 5 cycles after instr_valid → instr and instr_pc stable, imem_req stays 0, no further pc_write; one cycle of ready → next request at 0x0004.
- Redirect in HOLD: redirect_valid with target 0x5678 → pc_write with pc_next=0x5678, instr_valid drops, next imem_addr=0x5678, misaligned=0.
- Redirect in REQ before ack: target 0x0040, ack arrives 3 cycles later with 0xDEAD → 0xDEAD never appears on instr; next request is to 0x0040.
- Misaligned target and wrap: target 0x1235 → pc_next=0x1234 and a misaligned pulse. Starting at pc_cur=0xFFFE → after the ack, pc_next=0x0000.
- Reset mid-request: rst asserted while imem_req=1 → all outputs zero next cycle; after release, IDLE re-samples pc_cur (0x1236) and requests 0x1236.
